// File: rtl/num4bit_down.sv
// num4bit_down: synchronous down counter with parallel load, underflow
// borrow pulse, and wrap or one-shot stop at zero.
// Optional build macro: NUM4BIT_DOWN_BCD_EN selects a decade (mod-10) counter
// whose wrap target is 9 and whose load values above 9 are clamped to 9.
module num4bit_down #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             borrow,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef NUM4BIT_DOWN_BCD_EN
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(9);

  // Decade counting only makes sense on a 4-bit counter.
  if (WIDTH != 4) begin : g_bcd_width_check
    $error("num4bit_down: WIDTH must be 4 when NUM4BIT_DOWN_BCD_EN is defined");
  end
`else
  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             borrow_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] load_val;

  // Load value after optional clamping to the decade range.
`ifdef NUM4BIT_DOWN_BCD_EN
  assign load_val = (din > MAX_VAL) ? MAX_VAL : din;
`else
  assign load_val = din;
`endif

  // Terminal count: zero while actively counting.
  assign tc = (q == '0) && (state == RUN);

  // State and output registers; reset clears everything to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q      <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      borrow <= borrow_nxt;
      done   <= done_nxt;
    end
  end

  // Next state and next outputs: load beats count, count beats hold.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    borrow_nxt = 1'b0;
    done_nxt   = done;

    if (load) begin
      q_nxt     = load_val;
      state_nxt = RUN;
      done_nxt  = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (en) begin
            if (q != '0) begin
              q_nxt = q - WIDTH'(1);
            end else if (!mode) begin
              q_nxt      = MAX_VAL;
              borrow_nxt = 1'b1;
            end else begin
              borrow_nxt = 1'b1;
              done_nxt   = 1'b1;
              state_nxt  = DONE;
            end
          end
        end
        IDLE: begin
          state_nxt = IDLE;
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
          q_nxt     = '0;
          done_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule
